// File: rtl/fc_argmax_engine.sv
// Fully-connected layer with running argmax.
// Streams one feature/weight pair per cycle from external synchronous memories.
// Each class score is a saturated, scaled dot product. The best class is latched on completion.
module fc_argmax_engine #(
    parameter int unsigned N_IN    = 64,
    parameter int unsigned N_CLASS = 10,
    parameter int unsigned DW      = 16,
    parameter int unsigned WW      = 8,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned FRAC    = 8,
    localparam int unsigned KW = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int unsigned AW = (N_IN * N_CLASS > 1) ? $clog2(N_IN * N_CLASS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [KW-1:0]        feat_idx,
    input  logic signed [DW-1:0] feat_data,
    output logic [AW-1:0]        w_addr,
    input  logic signed [WW-1:0] w_data,
    input  logic [3:0]           sel,
    output logic signed [DW-1:0] score_out,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           best_class,
    output logic signed [DW-1:0] best_score
);

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StWrite, StDone} state_e;

    localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_e                  state_q, state_d;
    logic [KW-1:0]           k_q;
    logic [AW-1:0]           addr_q;
    logic [3:0]              c_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    acc_en_q;   // previous cycle was RUN: memory data is now valid
    logic signed [DW-1:0]    score_q [N_CLASS];
    logic [3:0]              run_class_q;
    logic signed [DW-1:0]    run_score_q;
    logic                    done_q;
    logic [3:0]              best_class_q;
    logic signed [DW-1:0]    best_score_q;

    logic                       last_k, last_c, take;
    logic signed [DW+WW-1:0]    prod;
    logic signed [ACC_W-1:0]    prod_ext, shifted;
    logic signed [DW-1:0]       sat_val;

    assign last_k   = (k_q == KW'(N_IN - 1));
    assign last_c   = (c_q == 4'(N_CLASS - 1));
    assign prod     = (DW+WW)'(feat_data) * (DW+WW)'(w_data);
    assign prod_ext = ACC_W'(prod);
    assign shifted  = acc_q >>> FRAC;

    // Saturate the scaled accumulator to the score range and decide the argmax update.
    always_comb begin
        sat_val = shifted[DW-1:0];
        if (shifted > SatMax) begin
            sat_val = SatMax[DW-1:0];
        end else if (shifted < SatMin) begin
            sat_val = SatMin[DW-1:0];
        end
        // Strict compare keeps the lower index on ties.
        take = (c_q == 4'd0) || (sat_val > run_score_q);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_k) state_d = StDrain;
            StDrain: state_d = StWrite;
            StWrite: state_d = last_c ? StDone : StRun;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath: address counters, accumulator, score array and argmax tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q          <= '0;
            addr_q       <= '0;
            c_q          <= '0;
            acc_q        <= '0;
            acc_en_q     <= 1'b0;
            run_class_q  <= '0;
            run_score_q  <= '0;
            done_q       <= 1'b0;
            best_class_q <= '0;
            best_score_q <= '0;
            for (int i = 0; i < N_CLASS; i++) begin
                score_q[i] <= '0;
            end
        end else begin
            acc_en_q <= (state_q == StRun);
            done_q   <= (state_q == StDone);

            if (acc_en_q) begin
                acc_q <= acc_q + prod_ext;
            end else if ((state_q == StWrite) || (state_q == StIdle && start)) begin
                acc_q <= '0;
            end

            if (state_q == StIdle && start) begin
                k_q    <= '0;
                addr_q <= '0;
                c_q    <= '0;
            end else if (state_q == StRun && !last_k) begin
                k_q    <= k_q + KW'(1);
                addr_q <= addr_q + AW'(1);
            end

            if (state_q == StWrite) begin
                for (int i = 0; i < N_CLASS; i++) begin
                    if (c_q == 4'(i)) score_q[i] <= sat_val;
                end
                if (take) begin
                    run_class_q <= c_q;
                    run_score_q <= sat_val;
                end
                if (!last_c) begin
                    c_q    <= c_q + 4'd1;
                    k_q    <= '0;
                    addr_q <= addr_q + AW'(1);
                end
            end

            if (state_q == StDone) begin
                best_class_q <= run_class_q;
                best_score_q <= run_score_q;
            end
        end
    end

    // Score readback; unused selects read as zero.
    always_comb begin
        score_out = '0;
        for (int i = 0; i < N_CLASS; i++) begin
            if (sel == 4'(i)) score_out = score_q[i];
        end
    end

    assign feat_idx   = k_q;
    assign w_addr     = addr_q;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign best_class = best_class_q;
    assign best_score = best_score_q;

endmodule

// File: tb/tb_fc_argmax_engine.sv
// Self-checking bench for fc_argmax_engine: small hand-checked configuration,
// table of directed default-size patterns, random patterns against a dot-product model,
// mid-inference reset and ignored start pulses.
module tb_fc_argmax_engine;

    localparam int NI = 64;
    localparam int NC = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default-size DUT.
    logic              start;
    logic [5:0]        feat_idx;
    logic signed [15:0] feat_data;
    logic [9:0]        w_addr;
    logic signed [7:0] w_data;
    logic [3:0]        sel;
    logic signed [15:0] score_out;
    logic              busy, done;
    logic [3:0]        best_class;
    logic signed [15:0] best_score;

    logic signed [15:0] feat_mem [NI];
    logic signed [7:0]  w_mem [NI*NC];

    fc_argmax_engine u_dut (
        .clk(clk), .rst(rst), .start(start),
        .feat_idx(feat_idx), .feat_data(feat_data),
        .w_addr(w_addr), .w_data(w_data),
        .sel(sel), .score_out(score_out),
        .busy(busy), .done(done),
        .best_class(best_class), .best_score(best_score)
    );

    always @(posedge clk) begin
        feat_data <= feat_mem[feat_idx];
        w_data    <= w_mem[w_addr];
    end

    // Small DUT: N_IN=4, N_CLASS=2, FRAC=0.
    logic              s_start;
    logic [1:0]        s_feat_idx;
    logic signed [15:0] s_feat_data;
    logic [2:0]        s_w_addr;
    logic signed [7:0] s_w_data;
    logic [3:0]        s_sel;
    logic signed [15:0] s_score_out;
    logic              s_busy, s_done;
    logic [3:0]        s_best_class;
    logic signed [15:0] s_best_score;

    logic signed [15:0] s_feat [4];
    logic signed [7:0]  s_w [8];

    fc_argmax_engine #(.N_IN(4), .N_CLASS(2), .FRAC(0)) u_small (
        .clk(clk), .rst(rst), .start(s_start),
        .feat_idx(s_feat_idx), .feat_data(s_feat_data),
        .w_addr(s_w_addr), .w_data(s_w_data),
        .sel(s_sel), .score_out(s_score_out),
        .busy(s_busy), .done(s_done),
        .best_class(s_best_class), .best_score(s_best_score)
    );

    always @(posedge clk) begin
        s_feat_data <= s_feat[s_feat_idx];
        s_w_data    <= s_w[s_w_addr];
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int f;
        int w;
        int hot;        // -1: every class uses w; else only this class does
        int exp_class;
        int exp_score;
        int exp_s0;
    } vec_t;

    vec_t vecs [5];

    task automatic load_pattern(input int f, input int w, input int hot);
        for (int k = 0; k < NI; k++) feat_mem[k] = 16'(f);
        for (int a = 0; a < NI*NC; a++)
            w_mem[a] = (hot < 0 || a / NI == hot) ? 8'(w) : 8'sd0;
    endtask

    // Runs one inference on the default DUT and compares against the model.
    task automatic run_check(input bit pulse, input string tag);
        longint acc, s, best_s;
        longint sc [NC];
        int best_c, cnt, addr_err, p, c, kk, extra_done;

        best_c = 0;
        best_s = 0;
        for (int ci = 0; ci < NC; ci++) begin
            acc = 0;
            for (int k = 0; k < NI; k++)
                acc += longint'(feat_mem[k]) * longint'(w_mem[ci*NI + k]);
            s = acc >>> 8;
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            sc[ci] = s;
            if (ci == 0 || s > best_s) begin
                best_c = ci;
                best_s = s;
            end
        end

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        cnt = 0;
        addr_err = 0;
        while (1) begin
            if (cnt < NC*(NI+2)) begin
                p  = cnt % (NI+2);
                c  = cnt / (NI+2);
                kk = (p < NI) ? p : NI-1;
                if (feat_idx != 6'(kk) || w_addr != 10'(c*NI + kk)) addr_err++;
            end
            if (done || cnt >= 2000) break;
            start = pulse && (cnt == 5 || cnt == 200);
            @(posedge clk);
            #1;
            cnt++;
        end
        start = 1'b0;
        check({tag, "_latency"}, cnt, 661);
        check({tag, "_addr_seq_errs"}, addr_err, 0);
        check({tag, "_best_class"}, best_class, best_c);
        check({tag, "_best_score"}, best_score, best_s);
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, done, 0);
        for (int si = 0; si < 16; si++) begin
            sel = 4'(si);
            #1;
            check($sformatf("%s_score%0d", tag, si), score_out, (si < NC) ? sc[si] : 0);
        end
        if (pulse) begin
            extra_done = 0;
            for (int i = 0; i < 700; i++) begin
                @(posedge clk);
                #1;
                if (done || busy) extra_done++;
            end
            check({tag, "_no_queued_start"}, extra_done, 0);
        end
    endtask

    initial begin
        int cnt, tmp;

        vecs[0] = '{f: 32767,  w: 127, hot: -1, exp_class: 0, exp_score: 32767,  exp_s0: 32767};
        vecs[1] = '{f: -32768, w: 127, hot: -1, exp_class: 0, exp_score: -32768, exp_s0: -32768};
        vecs[2] = '{f: 100,    w: 1,   hot: 7,  exp_class: 7, exp_score: 25,     exp_s0: 0};
        vecs[3] = '{f: 1,      w: -1,  hot: -1, exp_class: 0, exp_score: -1,     exp_s0: -1};
        vecs[4] = '{f: 300,    w: -5,  hot: 3,  exp_class: 0, exp_score: 0,      exp_s0: 0};

        s_feat = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        s_w    = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd2, 8'sd0, 8'sd0, 8'sd1};
        load_pattern(0, 0, -1);

        rst = 1'b1;
        start = 1'b0;
        s_start = 1'b0;
        sel = 4'd0;
        s_sel = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_feat_idx", feat_idx, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_best_class", best_class, 0);
        check("rst_best_score", best_score, 0);
        @(negedge clk);
        rst = 1'b0;

        // Small hand-checked case: scores 10 and 6.
        @(negedge clk);
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        cnt = 0;
        while (!s_done && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("small_latency", cnt, 13);
        check("small_best_class", s_best_class, 0);
        check("small_best_score", s_best_score, 10);
        s_sel = 4'd0; #1; check("small_score0", s_score_out, 10);
        s_sel = 4'd1; #1; check("small_score1", s_score_out, 6);
        s_sel = 4'd2; #1; check("small_score2", s_score_out, 0);

        // Directed pattern table.
        for (int i = 0; i < 5; i++) begin
            load_pattern(vecs[i].f, vecs[i].w, vecs[i].hot);
            run_check(1'b0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_tbl_class", i), best_class, vecs[i].exp_class);
            check($sformatf("vec%0d_tbl_score", i), best_score, vecs[i].exp_score);
            sel = 4'd0;
            #1;
            check($sformatf("vec%0d_tbl_s0", i), score_out, vecs[i].exp_s0);
        end

        // Random patterns.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NI; k++) begin
                tmp = int'($urandom_range(0, 4000)) - 2000;
                feat_mem[k] = 16'(tmp);
            end
            for (int a = 0; a < NI*NC; a++) begin
                tmp = int'($urandom_range(0, 255)) - 128;
                w_mem[a] = 8'(tmp);
            end
            run_check(1'b0, $sformatf("rand%0d", r));
        end

        // Mid-inference reset after a run that leaves nonzero state behind.
        load_pattern(100, 1, 7);
        run_check(1'b0, "pre_rst");
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (300) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        sel = 4'd7;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_feat_idx", feat_idx, 0);
        check("midrst_w_addr", w_addr, 0);
        check("midrst_best_class", best_class, 0);
        check("midrst_best_score", best_score, 0);
        check("midrst_score7", score_out, 0);
        @(negedge clk);
        rst = 1'b0;
        run_check(1'b0, "post_rst");

        // Start pulses while busy are ignored.
        for (int k = 0; k < NI; k++) feat_mem[k] = 16'(k * 37 - 1000);
        for (int a = 0; a < NI*NC; a++) w_mem[a] = 8'((a * 13) % 200 - 100);
        run_check(1'b1, "pulse");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
